// File: rtl/me_pkg.sv
// Motion-estimation shared constants and the reference row fetch state type.
// Used by the row fetcher and the downstream reference window buffer.
package me_pkg;

  localparam int PIX_W    = 8;
  localparam int ROW_PIX  = 23;
  localparam int WIN_ROWS = 8;
  localparam int WORD_PIX = 8;
  localparam int ROW_W    = ROW_PIX * PIX_W;
  localparam int WORD_W   = WORD_PIX * PIX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_HOLD,
    S_DONE
  } fetch_state_t;

endpackage

// File: rtl/ref_addr_gen.sv
// Frame-memory word address for window row r, word k.
// Define REF_FETCH_BOUND_CHK_EN to clamp rows to the bottom frame edge.
module ref_addr_gen
  import me_pkg::*;
#(
  parameter int FRAME_W_WORDS = 40,
  parameter int FRAME_H       = 240,
  parameter int ADDR_W        = 16
) (
  input  logic [7:0]        x0_word,
  input  logic [7:0]        y0,
  input  logic [2:0]        r,
  input  logic [1:0]        k,
  output logic [ADDR_W-1:0] mem_addr
);

  logic [ADDR_W-1:0] y;

  always_comb begin
    y = ADDR_W'(y0) + ADDR_W'(r);
`ifdef REF_FETCH_BOUND_CHK_EN
    // rows below the frame replicate the last frame row
    if (y > ADDR_W'(FRAME_H - 1))
      y = ADDR_W'(FRAME_H - 1);
`endif
  end

  assign mem_addr = ADDR_W'(y * ADDR_W'(FRAME_W_WORDS))
                  + ADDR_W'(x0_word)
                  + ADDR_W'(k);

endmodule

// File: rtl/ref_row_fetch.sv
// Fetches a 23x8 reference window row by row from frame memory.
// Optional bottom-edge clamp via REF_FETCH_BOUND_CHK_EN (in ref_addr_gen).
module ref_row_fetch
  import me_pkg::*;
#(
  parameter int FRAME_W_WORDS = 40,
  parameter int FRAME_H       = 240,
  parameter int ADDR_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        x0_word,
  input  logic [7:0]        y0,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [63:0]       mem_rd_data,
  output logic [ROW_W-1:0]  ref_data,
  output logic              ref_valid,
  input  logic              ref_ready,
  output logic              busy,
  output logic              done
);

  fetch_state_t state, state_d;
  logic [2:0] r, r_d;
  logic [1:0] k, k_d;
  logic       latch;
  logic [7:0] x0_q, y0_q;
  logic       rd_q;
  logic [1:0] k_q;
  logic [ADDR_W-1:0] addr;

  ref_addr_gen #(
    .FRAME_W_WORDS (FRAME_W_WORDS),
    .FRAME_H       (FRAME_H),
    .ADDR_W        (ADDR_W)
  ) u_addr_gen (
    .x0_word  (x0_q),
    .y0       (y0_q),
    .r        (r),
    .k        (k),
    .mem_addr (addr)
  );

  always_comb begin
    state_d = state;
    r_d     = r;
    k_d     = k;
    latch   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          latch   = 1'b1;
          r_d     = 3'd0;
          k_d     = 2'd0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (k == 2'd2) begin
          k_d     = 2'd0;
          state_d = S_WAIT;
        end else begin
          k_d = k + 2'd1;
        end
      end
      S_WAIT: state_d = S_HOLD;
      S_HOLD: begin
        if (ref_ready) begin
          if (r == 3'(WIN_ROWS - 1)) begin
            state_d = S_DONE;
          end else begin
            r_d     = r + 3'd1;
            state_d = S_READ;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_rd_en = (state == S_READ);
  assign mem_addr  = mem_rd_en ? addr : '0;
  assign ref_valid = (state == S_HOLD);
  assign done      = (state == S_DONE);
  assign busy      = (state == S_READ) || (state == S_WAIT)
                  || (state == S_HOLD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      r        <= 3'd0;
      k        <= 2'd0;
      x0_q     <= 8'd0;
      y0_q     <= 8'd0;
      rd_q     <= 1'b0;
      k_q      <= 2'd0;
      ref_data <= '0;
    end else begin
      state <= state_d;
      r     <= r_d;
      k     <= k_d;
      rd_q  <= mem_rd_en;
      k_q   <= k;
      if (latch) begin
        x0_q <= x0_word;
        y0_q <= y0;
      end
      // read data returns one cycle after issue; k_q tracks its slot
      if (rd_q) begin
        case (k_q)
          2'd0: ref_data[0 +: WORD_W] <= mem_rd_data;
          2'd1: ref_data[WORD_W +: WORD_W] <= mem_rd_data;
          2'd2: ref_data[2*WORD_W +: ROW_W-2*WORD_W]
                  <= mem_rd_data[ROW_W-2*WORD_W-1:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ref_row_fetch.sv
// Scoreboard bench for ref_row_fetch: directed windows, stalls,
// ignored starts, mid-fetch reset and bottom-edge rows.
module tb_ref_row_fetch;
  import me_pkg::*;

  localparam int FW = 40;
  localparam int FH = 240;
  localparam int AW = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [7:0]       x0_word = 8'd0;
  logic [7:0]       y0 = 8'd0;
  logic             mem_rd_en;
  logic [AW-1:0]    mem_addr;
  logic [63:0]      mem_rd_data = 64'd0;
  logic [ROW_W-1:0] ref_data;
  logic             ref_valid;
  logic             ref_ready = 1'b1;
  logic             busy;
  logic             done;

  ref_row_fetch #(
    .FRAME_W_WORDS (FW),
    .FRAME_H       (FH),
    .ADDR_W        (AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .x0_word     (x0_word),
    .y0          (y0),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .ref_data    (ref_data),
    .ref_valid   (ref_valid),
    .ref_ready   (ref_ready),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int cyc0 = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic [AW-1:0] a; } rd_t;
  typedef struct { int c; logic [ROW_W-1:0] d; } row_t;
  rd_t  rd_q[$];
  row_t row_q[$];
  int   done_q[$];

  function automatic logic [63:0] word_model(input logic [AW-1:0] a);
    logic [63:0] w;
    logic [AW+2:0] v;
    for (int b = 0; b < 8; b++) begin
      v = {a, 3'b000} + (AW+3)'(b);
      w[8*b +: 8] = v[7:0];
    end
    return w;
  endfunction

  always @(posedge clk)
    if (mem_rd_en) mem_rd_data <= word_model(mem_addr);

  function automatic logic [ROW_W-1:0] row_model(input logic [AW-1:0] base);
    logic [ROW_W-1:0] d;
    logic [63:0] w;
    for (int i = 0; i < ROW_PIX; i++) begin
      w = word_model(base + AW'(i / 8));
      d[8*i +: 8] = w[8*(i%8) +: 8];
    end
    return d;
  endfunction

  function automatic int exp_y(input int yy, input int r);
    int y;
    y = yy + r;
`ifdef REF_FETCH_BOUND_CHK_EN
    if (y > FH - 1) y = FH - 1;
`endif
    return y;
  endfunction

  task automatic chk(input string n, input logic [ROW_W-1:0] act,
                     input logic [ROW_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // Push the expected reads, handshakes and done for one window.
  task automatic plan(input int x, input int y, input int slo,
                      input int shi, input int cut, output int dcyc);
    int s, hs;
    logic [AW-1:0] base;
    s = 0;
    for (int r = 0; r < WIN_ROWS; r++) begin
      base = AW'(exp_y(y, r) * FW + x);
      for (int k = 0; k < 3; k++)
        if (s + 1 + k < cut) rd_q.push_back('{s + 1 + k, base + AW'(k)});
      hs = s + 5;
      while (hs >= slo && hs <= shi) hs++;
      if (hs < cut) row_q.push_back('{hs, row_model(base)});
      s = hs;
    end
    dcyc = s + 1;
    if (dcyc < cut) done_q.push_back(dcyc);
  endtask

  task automatic do_fetch(input int x, input int y, input int slo,
                          input int shi, input bit xs, input int rc);
    int dcyc, last;
    plan(x, y, slo, shi, (rc >= 0) ? rc + 1 : 1 << 20, dcyc);
    last = (rc >= 0) ? rc : dcyc;
    cyc0 = cyc;
    for (int t = 0; t <= last; t++) begin
      start     = (t == 0) || (xs && (t == 3 || t == 20));
      x0_word   = (t == 0) ? 8'(x) : 8'hAA;
      y0        = (t == 0) ? 8'(y) : 8'h55;
      ref_ready = !(t >= slo && t <= shi);
      rst_n     = !(t == rc);
      @(posedge clk);
      #1;
    end
    start     = 1'b0;
    ref_ready = 1'b1;
    rst_n     = 1'b1;
  endtask

  task automatic check_empty(input string n);
    chk({n, " reads left"}, ROW_W'(rd_q.size()), '0);
    chk({n, " rows left"}, ROW_W'(row_q.size()), '0);
    chk({n, " dones left"}, ROW_W'(done_q.size()), '0);
  endtask

  task automatic check_idle(input string n);
    chk({n, " rd_en"}, ROW_W'(mem_rd_en), '0);
    chk({n, " addr"}, ROW_W'(mem_addr), '0);
    chk({n, " data"}, ref_data, '0);
    chk({n, " flags"}, ROW_W'({ref_valid, busy, done}), '0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic             pv = 1'b0;
  logic             pr = 1'b0;
  logic [ROW_W-1:0] pd = '0;

  always @(negedge clk) begin
    int rel;
    rd_t  e;
    row_t w;
    int   dc;
    rel = cyc - cyc0;
    if (mem_rd_en) begin
      if (rd_q.size() == 0) begin
        chk("unexpected read", ROW_W'(mem_addr), '1);
      end else begin
        e = rd_q.pop_front();
        chk("read addr", ROW_W'(mem_addr), ROW_W'(e.a));
        chk("read cycle", ROW_W'(rel), ROW_W'(e.c));
      end
    end
    if (ref_valid && ref_ready) begin
      if (row_q.size() == 0) begin
        chk("unexpected row", ref_data, '1);
      end else begin
        w = row_q.pop_front();
        chk("row data", ref_data, w.d);
        chk("row cycle", ROW_W'(rel), ROW_W'(w.c));
      end
    end
    if (ref_valid && !ref_ready)
      chk("read in stall", ROW_W'(mem_rd_en), '0);
    if (pv && !pr && ref_valid)
      chk("row stable", ref_data, pd);
    if (done) begin
      chk("busy at done", ROW_W'(busy), '0);
      if (done_q.size() == 0) begin
        chk("unexpected done", ROW_W'(rel), '1);
      end else begin
        dc = done_q.pop_front();
        chk("done cycle", ROW_W'(rel), ROW_W'(dc));
      end
    end
    pv <= ref_valid;
    pr <= ref_ready;
    pd <= ref_data;
  end

  initial begin
    rst_n = 1'b0;
    idle(3);
    check_idle("reset");
    rst_n = 1'b1;
    idle(2);

    do_fetch(2, 10, -1, -1, 1'b0, -1);
    idle(2);
    check_empty("basic");

    do_fetch(5, 3, 5, 7, 1'b0, -1);
    idle(2);
    check_empty("stall");

    do_fetch(1, 50, -1, -1, 1'b1, -1);
    do_fetch(7, 0, -1, -1, 1'b0, -1);
    idle(2);
    check_empty("starts");

    do_fetch(3, 20, -1, -1, 1'b0, 12);
    check_idle("mid reset c13");
    idle(1);
    check_idle("mid reset c14");
    idle(3);
    check_empty("mid reset");

    do_fetch(0, 236, -1, -1, 1'b0, -1);
    idle(2);
    check_empty("bottom");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ref_row_fetch.md
# ref_row_fetch

Fetches a 23×8-pixel reference search window from reference-frame memory, one 23-pixel row at a time, and presents each row as a 184-bit word to the reference buffer stage over a valid/ready handshake. It sits directly upstream of the reference window buffer. It owns frame-memory address generation and the assembly of 64-bit memory words, each holding 8 pixels, into 23-pixel rows.

## Interface
- FRAME_W_WORDS, 40: frame line width in 64-bit words (320 px).
- FRAME_H, 240: frame height in rows. Used only with the bound-check feature.
- ADDR_W, 16: memory word-address width.
- clk  in  1  sole clock. All logic is on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle request to fetch a window. Sampled only in IDLE.
- x0_word  in  8  window left edge, in words (pixel x = 8·x0_word).
- y0  in  8  window top row.
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory word address.
- mem_rd_data  in  64  read data, 1-cycle latency. Pixel j is at [8j+7:8j].
- ref_data  out  184  row data. Pixel i is at [8i+7:8i].
- ref_valid  out  1  ref_data holds a complete row.
- ref_ready  in  1  downstream accepts the row.
- busy  out  1  a window fetch is in progress.
- done  out  1  one-cycle pulse after the 8th row is accepted.

## Operation
- State machine: IDLE, READ, WAIT, HOLD, DONE.
- IDLE
  - start=1 latches x0_word and y0, clears the row counter r (0..7), moves to READ.
  - start is ignored in every state other than IDLE.
- READ (3 cycles, word counter k = 0..2)
  - mem_rd_en=1.
  - mem_addr = (y0+r)·FRAME_W_WORDS + x0_word + k, computed modulo 2^ADDR_W.
  - After k=2, moves to WAIT.
- Capture
  - The word returned for index k lands in row pixels 8k..8k+7 on the cycle after it is issued.
  - For k=2, only pixels 16..22 are kept (bytes 0..6). Byte 7 is discarded.
- WAIT
  - Captures word 2, then moves to HOLD.
- HOLD
  - ref_valid=1. ref_data is held stable until ref_valid&ref_ready.
  - On handshake with r<7: r increments, moves to READ.
  - On handshake with r=7: moves to DONE.
- DONE (1 cycle)
  - done=1, busy=0, then moves to IDLE.
- busy=1 in READ, WAIT and HOLD.
- mem_rd_en=0 outside READ. No reads are issued while stalled in HOLD.
- Reset
  - Outputs reset to: mem_rd_en=0, mem_addr=0, ref_data=0, ref_valid=0, busy=0, done=0. State=IDLE, r=0, k=0.
  - Reset mid-fetch abandons the window silently: no done pulse, and a partially assembled row is discarded.

## Timing
- start sampled in cycle 0.
- Reads issued in cycles 1, 2, 3. Data captured at the end of cycles 2, 3, 4.
- ref_valid for row 0 first rises in cycle 5.
- With ref_ready held at 1, row r is valid in cycle 5+5r. Row 7 is valid in cycle 40, done is asserted in cycle 41, and the block is back in IDLE in cycle 42.
- Each cycle of ref_ready=0 in HOLD delays all later events by 1 cycle.
- The earliest new start is accepted in the first IDLE cycle.

## Configuration
- REF_FETCH_BOUND_CHK_EN defined
  - Row index is clamped: y = min(y0+r, FRAME_H−1).
  - Rows past the bottom edge replicate the last frame row.
- REF_FETCH_BOUND_CHK_EN undefined
  - y = y0+r, no clamping. Addresses wrap modulo 2^ADDR_W.
  - FRAME_H is unused.

## Structure
- Package me_pkg holds:
  - PIX_W=8, ROW_PIX=23, WIN_ROWS=8, WORD_PIX=8;
  - ROW_W=ROW_PIX·PIX_W (184);
  - the fetch state enum.
  - The downstream buffer also uses these constants.
- Sub-module ref_addr_gen
  - Combinational y-clamp plus multiply-add.
  - Inputs: x0_word, y0, r, k. Output: mem_addr.
  - Holds the REF_FETCH_BOUND_CHK_EN logic.
- All sequencing stays in ref_row_fetch.

## Test plan
- Basic fetch
  - Stimulus: x0_word=2, y0=10, ref_ready=1.
  - Row 0 reads at mem_addr 402, 403, 404. Row 7 reads at 682, 683, 684.
  - ref_valid in cycles 5, 10, …, 40. done in cycle 41.
- Assembly
  - Stimulus: memory returns each byte equal to its (address·8 + byte) low 8 bits.
  - Row 0: ref_data pixel i equals byte i of words 402..404, pixels 0..22. Byte 23 is absent.
- Backpressure
  - Stimulus: ref_ready=0 for cycles 5..7.
  - ref_data is unchanged over cycles 5..8 and mem_rd_en=0 in those cycles.
  - Row 1 reads occur in cycles 9..11. done is asserted in cycle 44.
- Start handling
  - Stimulus: start pulses in cycles 3 and 20, inside one fetch.
  - Both pulses are ignored. Exactly 8 handshakes and one done.
  - A start in cycle 42 begins a new fetch.
- Reset mid-fetch
  - Stimulus: rst_n=0 in cycle 12 for one cycle.
  - From cycle 13, all outputs are 0 and the block is in IDLE. No done.
- Bound check (REF_FETCH_BOUND_CHK_EN defined)
  - Stimulus: y0=236, x0_word=0.
  - Rows 4..7 all read addresses 9560..9562.
  - With the macro undefined, row 4 reads 9600..9602.
